// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: opcode values, FSM states, counter width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package md_pkg;

  localparam int MD_OP_W = 4;
  localparam int CNT_W   = 5;

  localparam logic [MD_OP_W-1:0] MD_NOP   = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  // Ops that occupy the unit for several cycles and commit to HI/LO at the end.
  function automatic logic is_long_op(input logic [MD_OP_W-1:0] op);
    return (op >= MD_MULT) && (op <= MD_MSUB);
  endfunction

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational 32/32 divider, signed or unsigned, with MIPS-style corner results.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever inputs are.
// Ports: a (dividend), b (divisor), is_signed; quo (quotient), rem (remainder).
module md_div_core (
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;

  // Signed division runs on magnitudes, signs are reapplied afterwards.
  // 0x80000000 negates to itself, which is the correct unsigned magnitude 2^31.
  assign abs_a = a[31] ? (32'd0 - a) : a;
  assign abs_b = b[31] ? (32'd0 - b) : b;
  assign dvd   = is_signed ? abs_a : a;
  // Divisor forced to 1 when zero so the core never divides by zero; the
  // zero-divisor result is substituted below.
  assign dvs   = (b == 32'd0) ? 32'd1 : (is_signed ? abs_b : b);
  assign uq    = dvd / dvs;
  assign ur    = dvd % dvs;

  always_comb begin
    quo = uq;
    rem = ur;
    if (b == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = a;
    end else if (is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      quo = 32'h8000_0000;
      rem = 32'd0;
    end else if (is_signed) begin
      // Quotient truncates toward zero; remainder follows the dividend sign.
      quo = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
      rem = a[31] ? (32'd0 - ur) : ur;
    end
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO owner for the EX stage: runs MULT/MULTU/MADD/MSUB/DIV/DIVU, serves MFHI/MFLO/MTHI/MTLO.
// Latency: MUL_CYCLES or DIV_CYCLES busy cycles per long op; MTxx one edge; MFxx combinational.
// Backpressure: MDBusy high while a long op is in flight; MDStart is ignored then (EX stalls).
// Ports: Clk, Rst (async active-low), MDOp/MDStart/A/B from EX; Out (MFHI/MFLO data), MDBusy.
module md_unit
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [MD_OP_W-1:0] MDOp,
  input  logic               MDStart,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  output logic [31:0]        Out,
  output logic               MDBusy
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      res_q;

  logic             commit_now;
  logic             start_long;
  logic [63:0]      base_hl;
  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic [31:0]      div_quo;
  logic [31:0]      div_rem;
  logic [63:0]      res_d;
  logic [CNT_W-1:0] cnt_load;

  assign commit_now = (state_q == ST_BUSY) && (cnt_q == '0);
  // A long op may also start on the commit edge of the previous one.
  assign start_long = MDStart && is_long_op(MDOp) &&
                      ((state_q == ST_IDLE) || commit_now);

  // MADD/MSUB accumulate onto the value HI/LO holds after this edge, which is
  // the pending result when starting on a commit edge.
  assign base_hl = commit_now ? res_q : {hi_q, lo_q};

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  md_div_core u_div (
    .is_signed (MDOp == MD_DIV),
    .a         (A),
    .b         (B),
    .quo       (div_quo),
    .rem       (div_rem)
  );

  always_comb begin
    res_d = '0;
    case (MDOp)
      MD_MULT:  res_d = prod_s;
      MD_MULTU: res_d = prod_u;
      MD_MADD:  res_d = base_hl + prod_s;
      MD_MSUB:  res_d = base_hl - prod_s;
      MD_DIV,
      MD_DIVU:  res_d = {div_rem, div_quo};
      default:  res_d = '0;
    endcase
  end

  assign cnt_load = is_div_op(MDOp) ? DIV_LOAD : MUL_LOAD;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_long) begin
            res_q   <= res_d;
            cnt_q   <= cnt_load;
            state_q <= ST_BUSY;
          end else if (MDStart && (MDOp == MD_MTHI)) begin
            hi_q <= A;
          end else if (MDStart && (MDOp == MD_MTLO)) begin
            lo_q <= A;
          end
        end
        ST_BUSY: begin
          if (commit_now) begin
            hi_q <= res_q[63:32];
            lo_q <= res_q[31:0];
            if (start_long) begin
              res_q <= res_d;
              cnt_q <= cnt_load;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MDBusy = (state_q == ST_BUSY);

  always_comb begin
    Out = '0;
    if (MDOp == MD_MFHI) Out = hi_q;
    else if (MDOp == MD_MFLO) Out = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_pkg::*;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [3:0]   MDOp;
  logic         MDStart;
  logic [31:0]  A;
  logic [31:0]  B;
  logic [31:0]  Out;
  logic         MDBusy;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [63:0]  exp_q[$];
  logic [63:0]  hl_m;

  md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .MDOp    (MDOp),
    .MDStart (MDStart),
    .A       (A),
    .B       (B),
    .Out     (Out),
    .MDBusy  (MDBusy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Rst && MDStart && MDBusy)
      $display("note: protocol violation - MDStart while MDBusy at %0t", $time);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model, written independently of the RTL datapath.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [31:0]     q, r;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_MADD:  return hl + 64'(sa * sb);
      MD_MSUB:  return hl - 64'(sa * sb);
      MD_DIV, MD_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'd0, 32'h8000_0000};
        if (op == MD_DIV) begin
          q = 32'(int'(a) / int'(b));
          r = 32'(int'(a) % int'(b));
        end else begin
          q = a / b;
          r = a % b;
        end
        return {r, q};
      end
      MD_MTHI:  return {a, hl[31:0]};
      MD_MTLO:  return {hl[63:32], a};
      default:  return hl;
    endcase
  endfunction

  // Drive one MD instruction for a single cycle; returns at the negedge after E0.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    MDOp = op; A = a; B = b; MDStart = 1'b1;
    @(negedge Clk);
    MDStart = 1'b0; MDOp = MD_NOP;
  endtask

  // Count busy cycles (bounded), optionally peeking HI or injecting a start mid-flight.
  task automatic wait_busy(input string tag, input int exp_n,
                           input int peek_at, input logic [31:0] peek_exp,
                           input int inj_at, input logic [3:0] inj_op, input logic [31:0] inj_a);
    int n = 0;
    while (MDBusy === 1'b1 && n < 64) begin
      if (n == inj_at) begin
        MDOp = inj_op; A = inj_a; B = 32'd5; MDStart = 1'b1;
      end else if (n == inj_at + 1) begin
        MDStart = 1'b0; MDOp = MD_NOP;
      end
      if (n == peek_at) begin
        MDOp = MD_MFHI;
        #1;
        check_eq({tag, "_hi_in_busy"}, 64'(Out), 64'(peek_exp));
        MDOp = MD_NOP;
      end
      n++;
      @(negedge Clk);
    end
    MDStart = 1'b0; MDOp = MD_NOP;
    check_eq({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
  endtask

  task automatic read_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    MDOp = MD_MFHI;
    #1;
    check_eq({tag, "_hi"}, 64'(Out), 64'(e[63:32]));
    MDOp = MD_MFLO;
    #1;
    check_eq({tag, "_lo"}, 64'(Out), 64'(e[31:0]));
    MDOp = MD_NOP;
  endtask

  // Issue an op with a hand-computed expected {HI,LO} and check it end to end.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_hl, input int exp_n);
    exp_q.push_back(exp_hl);
    hl_m = exp_hl;
    start_op(op, a, b);
    wait_busy(tag, exp_n, -1, 32'd0, -1, MD_NOP, 32'd0);
    read_check(tag);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] prev_hi;

    Rst = 1'b0; MDOp = MD_NOP; MDStart = 1'b0; A = '0; B = '0;
    hl_m = '0;
    #3;
    check_eq("reset_busy", 64'(MDBusy), 64'd0);
    exp_q.push_back(64'd0);
    read_check("reset");
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;

    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5);

    // MULTU with a peek of HI during busy: must still show the MULT result.
    prev_hi = hl_m[63:32];
    exp_q.push_back(64'h0000_0002_FFFF_FFFA);
    hl_m = 64'h0000_0002_FFFF_FFFA;
    start_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_busy("multu", 5, 2, prev_hi, -1, MD_NOP, 32'd0);
    read_check("multu");

    run_op("div",      MD_DIV,  32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 10);
    run_op("divu_by0", MD_DIVU, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF, 10);
    run_op("div_ovf",  MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10);

    run_op("mthi", MD_MTHI, 32'h1, 32'd0, {32'h1, hl_m[31:0]}, 0);
    run_op("mtlo", MD_MTLO, 32'hFFFF_FFFF, 32'd0, 64'h0000_0001_FFFF_FFFF, 0);
    run_op("madd", MD_MADD, 32'd1, 32'd1, 64'h0000_0002_0000_0000, 5);
    run_op("msub", MD_MSUB, 32'd1, 32'd1, 64'h0000_0001_FFFF_FFFF, 5);

    // Deliberate start while busy: both must be ignored, MULT result intact.
    exp_q.push_back(64'h0000_0000_0000_000C);
    hl_m = 64'h0000_0000_0000_000C;
    start_op(MD_MULT, 32'd3, 32'd4);
    wait_busy("ignore_mthi", 5, -1, 32'd0, 1, MD_MTHI, 32'hDEAD_BEEF);
    read_check("ignore_mthi");
    exp_q.push_back(hl_m);
    start_op(MD_MULT, 32'd6, 32'd7);
    wait_busy("ignore_mult", 5, -1, 32'd0, 2, MD_MULT, 32'h0000_0100);
    hl_m = 64'd42;
    exp_q.pop_back();
    exp_q.push_back(64'd42);
    read_check("ignore_mult");

    // Reset during busy cycle 3 aborts the op and clears HI/LO.
    start_op(MD_MULT, 32'd7, 32'd9);
    @(negedge Clk);
    @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    check_eq("rst_mid_busy", 64'(MDBusy), 64'd0);
    hl_m = '0;
    exp_q.push_back(64'd0);
    read_check("rst_mid");
    @(negedge Clk);
    Rst = 1'b1;
    repeat (8) @(negedge Clk);
    check_eq("rst_after_busy", 64'(MDBusy), 64'd0);
    exp_q.push_back(64'd0);
    read_check("rst_no_commit");

    // Randomised ops against the model.
    for (int i = 0; i < 10; i++) begin
      rop = 4'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'd0 : $urandom;
      hl_m = model(rop, ra, rb, hl_m);
      exp_q.push_back(hl_m);
      start_op(rop, ra, rb);
      wait_busy("rand", is_div_op(rop) ? 10 : 5, -1, 32'd0, -1, MD_NOP, 32'd0);
      read_check("rand");
    end

    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide responder for the EX stage of the 5-stage MIPS pipeline; owns the HI/LO register pair.
- EX is the initiator. It drives MDOp, MDStart and the forwarded operands, and stalls on MDBusy.
- md_unit executes the long-latency op, commits HI/LO when it finishes, and serves MFHI/MFLO reads combinationally on Out.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MSUB (range 1..31).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (range 1..31).

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous reset, active-low.
- MDOp  in  4  operation code (see Behaviour).
- MDStart  in  1  EX holds a valid MD-class instruction this cycle.
- A  in  32  operand rs (already forwarded by EX).
- B  in  32  operand rt (already forwarded by EX).
- Out  out  32  HI for MFHI, LO for MFLO, else 0; combinational.
- MDBusy  out  1  long-latency op in flight.

Behaviour:
- Op encoding (4 bits):
  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MSUB.
  - 7 MFHI, 8 MFLO, 9 MTHI, 10 MTLO.
  - 11-15 treated as NOP.
- Reset (Rst=0, asynchronous): HI=0, LO=0, state=IDLE, counter=0, MDBusy=0. Out follows MDOp against the cleared HI/LO.
- FSM states:
  - IDLE: MDBusy=0.
  - BUSY: MDBusy=1, counter counts down.
- IDLE + MDStart + op 1..6 at edge E0:
  - Latch the op and compute the 64-bit result from A/B sampled at E0.
  - Load counter with N-1, where N = MUL_CYCLES for ops 1,2,5,6 and DIV_CYCLES for ops 3,4. Go to BUSY.
- BUSY:
  - MDBusy=1 for exactly N cycles after E0.
  - At the edge ending the Nth cycle, write HI/LO and return to IDLE.
  - An MFHI/MFLO issued in the following cycle reads the new value.
- MDStart is ignored while BUSY for every op, including MTHI/MTLO. EX guarantees stalling; the bench flags any such start as a protocol violation.
- MTHI/MTLO (IDLE + MDStart): HI or LO takes A at the edge; MDBusy stays 0.
- MFHI/MFLO: Out=HI or LO whenever MDOp=7/8, independent of MDStart and of state. During BUSY it returns the old value.
- Arithmetic:
  - MULT: signed 32x32 to 64. MULTU: unsigned.
  - MADD: {HI,LO} += signed A*B, computed from the HI/LO value at E0. MSUB: -= signed A*B. Both wrap mod 2^64.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Division corner cases:
  - Divide by zero (DIV and DIVU): LO=0xFFFFFFFF, HI=A.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Reset mid-operation: the op is aborted, HI/LO are cleared, and nothing is committed afterwards.
- Back-to-back: a new op may start on the same edge the previous op commits. MDBusy deasserts for that cycle only if no MDStart arrives. EX combines MDStart into its own stall term.

Decomposition:
- Package md_pkg holds:
  - MD_OP width (4).
  - Op localparams MD_NOP..MD_MTLO (0..10).
  - State encoding IDLE/BUSY.
  - Counter width (5).
- Optional sub-module md_div_core:
  - Combinational signed/unsigned divider with the zero-divisor and overflow rules above.
  - Lets the datapath be swapped later for an iterative restoring divider without touching the FSM.
- The multiply datapath stays inline.

Test Plan:
- MULT A=0xFFFFFFFE, B=3 -> MDBusy high 5 cycles; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
- MULTU same operands -> after 5 cycles HI=0x00000002, LO=0xFFFFFFFA. MFHI issued during BUSY returns the prior HI.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Division corners:
  - DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
  - DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x1 and MTLO A=0xFFFFFFFF, then MADD A=1, B=1 -> no busy on MTxx; after 5 cycles HI=0x2, LO=0. MSUB A=1, B=1 -> HI=0x1, LO=0xFFFFFFFF.
- MULT started, Rst pulled low in busy cycle 3 -> MDBusy=0 immediately, HI=LO=0, no commit after Rst rises. A second MDStart during BUSY is ignored and the first result is unchanged.
